io_bus_arbiter: RTL

Ownership controller for a shared single-wire bidirectional bus (an inout net driven through `tran` connections by several leaf drivers). Grants drive rights to exactly one of N requesters at a time, round-robin. Inserts a fixed turnaround gap with no driver between owners, and forcibly reclaims the bus from an owner that holds it too long. The per-requester grant bits are the drive enables of the leaf tristate drivers, so at most one driver is ever enabled.

---
 rtl/io_bus_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin ownership controller for a shared bidirectional bus.
// Inserts a driverless turnaround gap and reclaims over-long holds.
module io_bus_arbiter #(
  parameter int N        = 4,
  parameter int TA       = 2,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] owner,
  output logic           owner_valid,
  output logic           bus_turn,
  output logic           timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TA > 1) ? $clog2(TA) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold;
  logic [TW-1:0]  turn_cnt;

  logic [IDW-1:0] win;
  logic [IDW-1:0] win_nxt;
  logic [IDW:0]   scan;
  logic           found;
  logic           rel_user;
  logic           rel_force;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(N))
        scan = scan - (IDW+1)'(N);
      if (!found && req[scan[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
  end

  assign win_nxt = (win == IDW'(N-1)) ? '0 : win + IDW'(1);

  assign rel_user  = done[owner] | ~req[owner];
  assign rel_force = (MAX_HOLD != 0)
                   && (hold == HW'(MAX_HOLD-1))
                   && !rel_user;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold        <= '0;
      turn_cnt    <= '0;
      grant       <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      bus_turn    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state       <= OWN;
            grant       <= {{(N-1){1'b0}}, 1'b1} << win;
            owner       <= win;
            owner_valid <= 1'b1;
            hold        <= '0;
            ptr         <= win_nxt;
          end
        end
        OWN: begin
          if (rel_user || rel_force) begin
            state       <= TURN;
            grant       <= '0;
            owner_valid <= 1'b0;
            bus_turn    <= 1'b1;
            turn_cnt    <= TW'(TA-1);
            timeout     <= rel_force;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        TURN: begin
          if (turn_cnt == '0) begin
            bus_turn <= 1'b0;
            if (found) begin
              state       <= OWN;
              grant       <= {{(N-1){1'b0}}, 1'b1} << win;
              owner       <= win;
              owner_valid <= 1'b1;
              hold        <= '0;
              ptr         <= win_nxt;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
